sub16_serial: RTL

Multi-cycle 16-bit subtractor. It computes D = A - B - Bin one 4-bit slice per clock, using a single 4-bit subtract slice and a registered borrow chain. It is the subtraction counterpart of the team's 16-bit adder datapath and is used where area matters more than latency. The block takes a Start pulse and returns a one-cycle Done pulse together with the difference and flags.

---
 rtl/sub16_serial_pkg.sv | 15 +
 rtl/sub16_serial_slice.sv | 15 +
 rtl/sub16_serial.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sub16_serial_pkg.sv
// Shared constants and FSM encoding for the bit-sliced serial subtractor.
package sub16_serial_pkg;

   localparam int WIDTH  = 16;
   localparam int SLICE  = 4;
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub16_serial_slice.sv
// One SLICE-wide subtract step: d = a + ~b + cin, with the carry out
// acting as the inverted borrow for the next slice.
module sub_4b_slice
   import sub16_serial_pkg::*;
(
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] d,
   output logic             cout
);

   assign {cout, d} = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle WIDTH-bit subtractor: one SLICE per clock through a single
// shared slice, LSB slice first, with the borrow carried in a register.
module sub16_serial
   import sub16_serial_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             Z
);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  work_q, work_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic              bout_q, bout_d;
   logic              v_q, v_d;
   logic              z_q, z_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [SLICE-1:0]  slice_a_s;
   logic [SLICE-1:0]  slice_b_s;
   logic [SLICE-1:0]  slice_d_s;
   logic              slice_cout_s;
   logic [WIDTH-1:0]  work_upd_s;

   sub_4b_slice u_slice (
      .a    (slice_a_s),
      .b    (slice_b_s),
      .cin  (carry_q),
      .d    (slice_d_s),
      .cout (slice_cout_s)
   );

   // Operand slice selection and work register with the current slice merged in
   always_comb begin
      slice_a_s  = a_q[int'(idx_q) * SLICE +: SLICE];
      slice_b_s  = b_q[int'(idx_q) * SLICE +: SLICE];
      work_upd_s = work_q;
      work_upd_s[int'(idx_q) * SLICE +: SLICE] = slice_d_s;
   end

   // Next-state logic: operand capture, slice stepping and result publication
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      d_d     = d_q;
      bout_d  = bout_q;
      v_d     = v_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               // Subtraction as A + ~B + 1 - Bin: the initial carry is ~Bin.
               a_d     = A;
               b_d     = B;
               carry_d = ~Bin;
               idx_d   = {IDXW{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            work_d  = work_upd_s;
            carry_d = slice_cout_s;
            idx_d   = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
            if (idx_q == IDXW'(NSLICE - 1)) begin
               // Last slice: publish result, a final carry of 0 means a borrow.
               state_d = ST_DONE;
               d_d     = work_upd_s;
               bout_d  = ~slice_cout_s;
               v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (work_upd_s[WIDTH-1] != a_q[WIDTH-1]);
               z_d     = (work_upd_s == {WIDTH{1'b0}});
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with synchronous reset taking priority
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         idx_q   <= {IDXW{1'b0}};
         carry_q <= 1'b0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         work_q  <= {WIDTH{1'b0}};
         d_q     <= {WIDTH{1'b0}};
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
         z_q     <= z_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign D    = d_q;
   assign Bout = bout_q;
   assign V    = v_q;
   assign Z    = z_q;

endmodule
